// File: rtl/charbuf_reader_if.sv
// Handshake/data bundle between a character-buffer producer/consumer and charbuf_reader.
interface charbuf_reader_if;
    logic        load;
    logic [31:0] buf_in;
    logic        out_ready;
    logic [3:0]  out_char;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [3:0]  remaining;

    modport master (
        output load, buf_in, out_ready,
        input  out_char, out_valid, busy, done, remaining
    );

    modport slave (
        input  load, buf_in, out_ready,
        output out_char, out_valid, busy, done, remaining
    );
endinterface

// File: rtl/charbuf_reader.sv
// Streams the nibble characters of a 32-bit buffer oldest first, skipping leading empty slots.
// Optional abort input is enabled by defining CHARBUF_READER_ABORT_EN.
module charbuf_reader (
    input logic clk,
    input logic rst,
`ifdef CHARBUF_READER_ABORT_EN
    input logic abort,
`endif
    charbuf_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] shreg, shreg_n;
    logic [3:0]  slots, slots_n;
    logic        kill;

    always_comb begin
        kill    = 1'b0;
`ifdef CHARBUF_READER_ABORT_EN
        kill    = abort && (state == SCAN || state == SEND);
`endif
        state_n = state;
        shreg_n = shreg;
        slots_n = slots;
        case (state)
            IDLE: if (bus.load) begin
                shreg_n = bus.buf_in;
                slots_n = 4'd8;
                state_n = SCAN;
            end
            SCAN: if (shreg[31:28] != 4'h0) begin
                state_n = SEND;
            end else if (slots > 4'd1) begin
                shreg_n = {shreg[27:0], 4'h0};
                slots_n = slots - 4'd1;
            end else begin
                slots_n = 4'd0;
                state_n = DONE;
            end
            SEND: if (bus.out_ready) begin
                shreg_n = {shreg[27:0], 4'h0};
                slots_n = slots - 4'd1;
                if (slots == 4'd1) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) begin
            state_n = IDLE;
            shreg_n = 32'h0;
            slots_n = 4'd0;
        end
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= 32'h0;
            slots         <= 4'd0;
            bus.out_valid <= 1'b0;
            bus.out_char  <= 4'h0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.remaining <= 4'd0;
        end else begin
            state         <= state_n;
            shreg         <= shreg_n;
            slots         <= slots_n;
            bus.out_valid <= (state_n == SEND);
            bus.out_char  <= (state_n == SEND) ? shreg_n[31:28] : 4'h0;
            bus.busy      <= (state_n == SCAN) || (state_n == SEND);
            bus.done      <= (state_n == DONE);
            bus.remaining <= (state_n == SCAN || state_n == SEND) ? slots_n : 4'd0;
        end
    end
endmodule

// File: tb/tb_charbuf_reader.sv
// Self-checking bench for charbuf_reader: vector table plus hand-written multi-cycle sequences.
module tb_charbuf_reader;
    logic clk = 1'b0;
    logic rst;
`ifdef CHARBUF_READER_ABORT_EN
    logic abort = 1'b0;
`endif
    charbuf_reader_if bus ();

    charbuf_reader dut (
        .clk(clk),
        .rst(rst),
`ifdef CHARBUF_READER_ABORT_EN
        .abort(abort),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // expected tuple: {out_valid, out_char, busy, done, remaining}
    typedef struct {
        logic        ld;
        logic [31:0] b;
        logic        rdy;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t vt[$];
    int   n_chk = 0;
    int   n_pass = 0;

    function automatic logic [10:0] ex(input logic v, input logic [3:0] c, input logic bz,
                                       input logic d, input logic [3:0] rem);
        return {v, c, bz, d, rem};
    endfunction

    function automatic logic [10:0] outs();
        return {bus.out_valid, bus.out_char, bus.busy, bus.done, bus.remaining};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got v=%b c=%h busy=%b done=%b rem=%0d, want v=%b c=%h busy=%b done=%b rem=%0d",
                      name, act[10], act[9:6], act[5], act[4], act[3:0],
                      expv[10], expv[9:6], expv[5], expv[4], expv[3:0]);
    endtask

    task automatic step(input logic ld, input logic [31:0] b, input logic rdy);
        bus.load = ld;
        bus.buf_in = b;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic ld, input logic [31:0] b, input logic rdy,
                                input logic [10:0] e, input string n);
        vec_t x;
        x.ld = ld; x.b = b; x.rdy = rdy; x.exp = e; x.name = n;
        vt.push_back(x);
    endfunction

    task automatic collect(input string name, input logic [31:0] b, input logic [3:0] expq[$]);
        logic [3:0] got[$];
        int cyc = 0;
        bit seen_done = 0;
        step(1'b1, b, 1'b1);
        while (!seen_done && cyc < 40) begin
            if (bus.out_valid) got.push_back(bus.out_char);
            if (bus.done) seen_done = 1;
            // a fresh load while reading must be ignored
            if (!seen_done) step(bus.out_valid, 32'hFFFF_FFFF, 1'b1);
            cyc++;
        end
        n_chk++;
        if (seen_done && got == expq) n_pass++;
        else $display("FAIL %s: got %0d chars (done=%0b) %p, want %p", name, got.size(), seen_done, got, expq);
    endtask

    initial begin
        logic [3:0] q[$];
        bus.load = 1'b0;
        bus.buf_in = 32'h0;
        bus.out_ready = 1'b0;

        rst = 1'b1;
        step(1'b1, 32'h1234_5678, 1'b1);
        step(1'b1, 32'h1234_5678, 1'b1);
        check("reset", outs(), ex(0, 0, 0, 0, 0));
        rst = 1'b0;

        // 0x00000123: five skipped slots, then 1,2,3; a load during SEND is ignored
        add(1, 32'h0000_0123, 1, ex(0, 0, 1, 0, 8), "s123_c1");
        add(0, 32'h0,         1, ex(0, 0, 1, 0, 7), "s123_c2");
        add(0, 32'h0,         1, ex(0, 0, 1, 0, 6), "s123_c3");
        add(0, 32'h0,         1, ex(0, 0, 1, 0, 5), "s123_c4");
        add(0, 32'h0,         1, ex(0, 0, 1, 0, 4), "s123_c5");
        add(0, 32'h0,         1, ex(0, 0, 1, 0, 3), "s123_c6");
        add(0, 32'h0,         1, ex(1, 1, 1, 0, 3), "s123_c7");
        add(1, 32'hFFFF_FFFF, 1, ex(1, 2, 1, 0, 2), "s123_c8");
        add(0, 32'h0,         1, ex(1, 3, 1, 0, 1), "s123_c9");
        add(1, 32'hFFFF_FFFF, 1, ex(0, 0, 0, 1, 0), "s123_c10");
        add(0, 32'h0,         1, ex(0, 0, 0, 0, 0), "s123_c11");
        // all-empty buffer: busy 8 cycles, nothing emitted, done in cycle 9
        add(1, 32'h0, 1, ex(0, 0, 1, 0, 8), "zero_c1");
        for (int i = 2; i <= 8; i++)
            add(0, 32'h0, 1, ex(0, 0, 1, 0, 4'(9 - i)), $sformatf("zero_c%0d", i));
        add(0, 32'h0, 1, ex(0, 0, 0, 1, 0), "zero_c9");
        add(0, 32'h0, 1, ex(0, 0, 0, 0, 0), "zero_c10");

        foreach (vt[i]) begin
            step(vt[i].ld, vt[i].b, vt[i].rdy);
            check(vt[i].name, outs(), vt[i].exp);
        end

        // backpressure on a full buffer
        step(1, 32'h1234_5678, 0);
        check("bp_scan", outs(), ex(0, 0, 1, 0, 8));
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 0);
            check($sformatf("bp_hold%0d", i), outs(), ex(1, 1, 1, 0, 8));
        end
        for (int i = 1; i <= 7; i++) begin
            step(0, 32'h0, 1);
            check($sformatf("bp_char%0d", i + 1), outs(), ex(1, 4'(i + 1), 1, 0, 4'(8 - i)));
        end
        step(0, 32'h0, 1);
        check("bp_done", outs(), ex(0, 0, 0, 1, 0));
        step(0, 32'h0, 1);
        check("bp_idle", outs(), ex(0, 0, 0, 0, 0));

        // interior zero is emitted
        q = '{4'h1, 4'h0, 4'h5};
        collect("s105", 32'h0000_0105, q);
        step(0, 32'h0, 1);
        check("s105_idle", outs(), ex(0, 0, 0, 0, 0));

        // reset after two accepted chars of 0x00004567
        step(1, 32'h0000_4567, 1);
        for (int i = 0; i < 5; i++) step(0, 32'h0, 1);
        check("rst_c4", outs(), ex(1, 4, 1, 0, 4));
        step(0, 32'h0, 1);
        step(0, 32'h0, 1);
        check("rst_c6", outs(), ex(1, 6, 1, 0, 2));
        rst = 1'b1;
        step(1, 32'h0000_4567, 1);
        rst = 1'b0;
        check("rst_mid", outs(), ex(0, 0, 0, 0, 0));
        step(0, 32'h0, 1);
        check("rst_nodone", outs(), ex(0, 0, 0, 0, 0));

`ifdef CHARBUF_READER_ABORT_EN
        step(1, 32'h0000_4567, 1);
        for (int i = 0; i < 7; i++) step(0, 32'h0, 1);
        check("ab_c6", outs(), ex(1, 6, 1, 0, 2));
        abort = 1'b1;
        step(0, 32'h0, 1);
        abort = 1'b0;
        check("abort_mid", outs(), ex(0, 0, 0, 0, 0));
        step(0, 32'h0, 1);
        check("abort_nodone", outs(), ex(0, 0, 0, 0, 0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/charbuf_reader.md
CHARBUF_READER -- requirements
Module: charbuf_reader

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: load  input  1  request to capture buf_in; sampled only in IDLE.
REQ-004 SHALL have port: buf_in  input  32  packed characters, 8 nibble slots; slot 7 [31:28] oldest, slot 0 [3:0] newest; leading 4'h0 slots are empty.
REQ-005 SHALL have port: out_ready  input  1  consumer accepts out_char this cycle.
REQ-006 SHALL have port: out_char  output  4  current character, oldest first.
REQ-007 SHALL have port: out_valid  output  1  out_char is valid; high only in SEND.
REQ-008 SHALL have port: busy  output  1  high in SCAN or SEND.
REQ-009 SHALL have port: done  output  1  single-cycle pulse when a buffer has been fully read.
REQ-010 SHALL have port: remaining  output  4  unread slots including current, 0..8.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, SEND, DONE, plus 32-bit shift register shreg and 4-bit slot counter slots.
REQ-012 IDLE: load=1 at an edge -> shreg<=buf_in, slots<=8, next SCAN; load=0 -> stay IDLE.
REQ-013 SCAN, top nibble shreg[31:28]!=0 -> next SEND, no shift.
REQ-014 SCAN, top nibble==0, slots>1 -> shreg<=shreg<<4 (zero fill), slots<=slots-1, stay SCAN (one empty slot skipped per cycle).
REQ-015 SCAN, top nibble==0, slots==1 -> slots<=0, next DONE (all-empty buffer, nothing emitted).
REQ-016 SEND: out_valid=1, out_char=shreg[31:28]; out_char held stable while out_ready=0.
REQ-017 SEND with out_ready=1: shreg<=shreg<<4, slots<=slots-1; slots==1 -> next DONE, else stay SEND; one character per cycle at full throughput.
REQ-018 Zero nibbles after the first nonzero character SHALL be emitted as character 4'h0 (interior zeros are not skipped).
REQ-019 DONE: done=1 for exactly one cycle, next IDLE; load in DONE ignored.
REQ-020 load while busy or in DONE SHALL be ignored; buf_in changes after capture SHALL have no effect.
REQ-021 remaining SHALL equal slots in SCAN/SEND, 0 in IDLE and DONE.
REQ-022 out_char SHALL be 4'h0 whenever out_valid=0.
REQ-023 Latency: load sampled at edge 0 with k leading empty slots (k<8) -> out_valid first high in cycle k+2.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, shreg=0, slots=0, out_valid=0, out_char=0, busy=0, done=0, remaining=0, in any state.
REQ-025 rst SHALL take priority over load, out_ready and abort; reset mid-SCAN/SEND SHALL produce no done pulse.

Configuration
REQ-026 Macro CHARBUF_READER_ABORT_EN SHALL control an abort input (1 bit).
REQ-027 With CHARBUF_READER_ABORT_EN defined: abort=1 at an edge in SCAN or SEND -> next IDLE, shreg=0, slots=0, no done pulse; ignored in IDLE/DONE; lower priority than rst.
REQ-028 Without CHARBUF_READER_ABORT_EN: abort port absent; reading ends only by completion or rst.

Verification
REQ-029 Reset: rst=1 one edge from any state -> all outputs 0 next cycle, state IDLE.
REQ-030 load buf_in=32'h00000123, out_ready=1 -> remaining 8..4 during skip, out_valid cycles 7-9 with out_char 1,2,3, done pulse cycle 10, then idle.
REQ-031 load buf_in=32'h00000000 -> busy 8 cycles, out_valid never high, done pulse cycle 9.
REQ-032 load 32'h12345678, out_ready=0 for 3 cycles -> out_char held 4'h1, remaining 8; then out_ready=1 -> 1..8 on consecutive cycles, done after 8.
REQ-033 load 32'h00000105 -> emitted 1,0,5; load 32'hFFFFFFFF asserted again while SEND -> ignored, stream unchanged.
REQ-034 rst=1 after 2 accepted chars of 32'h00004567 -> IDLE next cycle, no done; with macro, abort=1 same point -> IDLE, no done.
